// File: rtl/axi_rd_arb_pkg.sv
// Shared types and AXI constants for the read-channel arbiter.
// Consumed by axi_rd_arbiter and rr_arb2.
package axi_rd_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } state_e;

  typedef enum logic {
    M0,
    M1
  } owner_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [3:0] AXI_CACHE_MOD  = 4'b0011;
  localparam logic [2:0] AXI_PROT_INSN  = 3'b100;
  localparam logic [2:0] AXI_PROT_DATA  = 3'b000;

endpackage

// File: rtl/axi_rd_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: a tie goes to the requester
// that did not win last time.
module rr_arb2
  import axi_rd_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       en,
  input  owner_e     last_grant,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      unique case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (last_grant == M1) ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI4 read master between fetch (m0) and LSU (m1).
// Optional watchdog: define AXI_RD_ARB_TIMEOUT_EN.
module axi_rd_arbiter
  import axi_rd_arb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int ID_W        = 4,
  parameter int M0_ID       = 0,
  parameter int M1_ID       = 1,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req_valid,
  output logic              m0_req_ready,
  input  logic [ADDR_W-1:0] m0_req_addr,
  input  logic [7:0]        m0_req_len,
  output logic              m0_rsp_valid,
  output logic [DATA_W-1:0] m0_rsp_data,
  output logic              m0_rsp_err,
  output logic              m0_rsp_last,
  input  logic              m1_req_valid,
  output logic              m1_req_ready,
  input  logic [ADDR_W-1:0] m1_req_addr,
  input  logic [7:0]        m1_req_len,
  output logic              m1_rsp_valid,
  output logic [DATA_W-1:0] m1_rsp_data,
  output logic              m1_rsp_err,
  output logic              m1_rsp_last,
  output logic [ID_W-1:0]   axi_arid,
  output logic [ADDR_W-1:0] axi_araddr,
  output logic [7:0]        axi_arlen,
  output logic [2:0]        axi_arsize,
  output logic [1:0]        axi_arburst,
  output logic              axi_arlock,
  output logic [3:0]        axi_arcache,
  output logic [2:0]        axi_arprot,
  output logic [3:0]        axi_arqos,
  output logic [3:0]        axi_arregion,
  output logic              axi_arvalid,
  input  logic              axi_arready,
  input  logic [ID_W-1:0]   axi_rid,
  input  logic [DATA_W-1:0] axi_rdata,
  input  logic [1:0]        axi_rresp,
  input  logic              axi_rlast,
  input  logic              axi_rvalid,
  output logic              axi_rready
);

  state_e            r_state;
  owner_e            r_owner;
  owner_e            r_last;
  logic [ID_W-1:0]   r_arid;
  logic [ADDR_W-1:0] r_araddr;
  logic [7:0]        r_arlen;
  logic [2:0]        r_arprot;
  logic              r_arvalid;
  logic [8:0]        r_beat;

  logic [1:0] w_gnt;
  logic       w_hs;
  logic       w_beat;
  logic       w_err;
  logic       w_tmo;
  logic       w_sel0;
  logic       w_sel1;
  logic       w_unused;

  rr_arb2 u_arb (
    .req        ({m1_req_valid, m0_req_valid}),
    .en         (r_state == IDLE),
    .last_grant (r_last),
    .gnt        (w_gnt)
  );

  assign w_hs   = r_arvalid & axi_arready;
  assign w_beat = (r_state == DATA) & axi_rvalid;
  assign w_sel0 = (r_owner == M0);
  assign w_sel1 = (r_owner == M1);

  // Beat counter is 9 bits so overrun past len stays distinguishable.
  assign w_err = (axi_rresp[1] != AXI_RESP_OKAY[1])
               | (axi_rid != r_arid)
               | (axi_rlast ? (r_beat != {1'b0, r_arlen})
                            : (r_beat >= {1'b0, r_arlen}));

`ifdef AXI_RD_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] r_tmo;

  assign w_tmo = (r_state != IDLE) & ~w_hs & ~w_beat
               & (r_tmo == TMO_W'(TIMEOUT_CYC));
  assign w_unused = axi_rresp[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo <= '0;
    end else if ((r_state == IDLE) | w_hs | w_beat) begin
      r_tmo <= '0;
    end else if (!w_tmo) begin
      r_tmo <= r_tmo + 1'b1;
    end
  end
`else
  assign w_tmo    = 1'b0;
  assign w_unused = axi_rresp[0] ^ (TIMEOUT_CYC != 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_owner   <= M0;
      r_last    <= M1;
      r_arid    <= '0;
      r_araddr  <= '0;
      r_arlen   <= '0;
      r_arprot  <= '0;
      r_arvalid <= 1'b0;
      r_beat    <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_beat <= '0;
          if (|w_gnt) begin
            r_owner   <= w_gnt[1] ? M1 : M0;
            r_last    <= w_gnt[1] ? M1 : M0;
            r_arid    <= w_gnt[1] ? ID_W'(M1_ID) : ID_W'(M0_ID);
            r_araddr  <= w_gnt[1] ? m1_req_addr : m0_req_addr;
            r_arlen   <= w_gnt[1] ? m1_req_len : m0_req_len;
            r_arprot  <= w_gnt[1] ? AXI_PROT_DATA : AXI_PROT_INSN;
            r_arvalid <= 1'b1;
            r_state   <= ADDR;
          end
        end
        ADDR: begin
          if (w_hs) begin
            r_arvalid <= 1'b0;
            r_state   <= DATA;
          end else if (w_tmo) begin
            r_arvalid <= 1'b0;
            r_state   <= IDLE;
          end
        end
        DATA: begin
          if (w_beat) begin
            if (r_beat != '1) r_beat <= r_beat + 1'b1;
            if (axi_rlast) r_state <= IDLE;
          end else if (w_tmo) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign m0_req_ready = rst_n & w_gnt[0];
  assign m1_req_ready = rst_n & w_gnt[1];

  assign m0_rsp_valid = w_sel0 & (w_beat | w_tmo);
  assign m0_rsp_data  = (w_sel0 & w_beat) ? axi_rdata : '0;
  assign m0_rsp_err   = w_sel0 & (w_tmo | (w_beat & w_err));
  assign m0_rsp_last  = w_sel0 & (w_tmo | (w_beat & axi_rlast));

  assign m1_rsp_valid = w_sel1 & (w_beat | w_tmo);
  assign m1_rsp_data  = (w_sel1 & w_beat) ? axi_rdata : '0;
  assign m1_rsp_err   = w_sel1 & (w_tmo | (w_beat & w_err));
  assign m1_rsp_last  = w_sel1 & (w_tmo | (w_beat & axi_rlast));

  assign axi_arid     = r_arid;
  assign axi_araddr   = r_araddr;
  assign axi_arlen    = r_arlen;
  assign axi_arprot   = r_arprot;
  assign axi_arvalid  = r_arvalid;
  assign axi_arsize   = AXI_SIZE_4B;
  assign axi_arburst  = AXI_BURST_INCR;
  assign axi_arlock   = 1'b0;
  assign axi_arcache  = AXI_CACHE_MOD;
  assign axi_arqos    = 4'b0;
  assign axi_arregion = 4'b0;
  assign axi_rready   = (r_state == DATA);

endmodule
